dmem_write_monitor: RTL and testbench
=====================================

// Module: dmem_write_monitor
// PURPOSE
//   Sits between the CPU data-memory port and the pass/fail checker in the simulation bench.
//   Turns stall-held store requests into exactly one commit event per completed store.
//   Buffers commit events in a small FIFO that the checker drains with a valid/ready handshake.
//   Also provides a store counter, a run-cycle counter and a watchdog timeout flag.
// PARAMETERS
//   DEPTH      4        FIFO entries; power of two, 2..16
//   PTR_W      2        log2(DEPTH)
//   TIMEOUT    16'd5000 cycle count at which timeout sets
// PORTS
//   clk          in   1   clock; all logic on posedge
//   rst          in   1   synchronous reset, active-high
//   mem_addr     in   30  word address of the CPU data-memory access
//   mem_wdata    in   32  store data
//   mem_wen      in   1   store request; held high while the D-cache stalls
//   mem_stall    in   1   D-cache stall; the store completes on a cycle with mem_wen=1 and mem_stall=0
//   stop         in   1   checker finish; freezes cycle_count
//   ev_valid     out  1   FIFO head is valid
//   ev_addr      out  30  head address
//   ev_data      out  32  head data
//   ev_ready     in   1   consumer accepts the head when ev_valid & ev_ready
//   write_count  out  16  committed stores since reset, saturating at 16'hFFFF
//   cycle_count  out  16  cycles since reset, saturating at 16'hFFFF
//   overflow     out  1   sticky: a commit was dropped because the FIFO was full
//   timeout      out  1   sticky: cycle_count reached TIMEOUT
// BEHAVIOUR
//   Reset (sampled at posedge):
//   - pointers, occupancy, write_count, cycle_count, overflow and timeout all go to 0.
//   - ev_valid=0; ev_addr and ev_data read 0.
//   - Reset in mid-operation discards every buffered event.
//   commit = mem_wen & ~mem_stall (combinational).
//   - Each such cycle is one store, including back-to-back identical stores.
//   - Stall cycles never commit.
//   Push:
//   - On commit, {mem_addr, mem_wdata} is written at wr_ptr at the posedge.
//   - The entry is visible on ev_* the next cycle. No same-cycle bypass, so min latency is 1 cycle.
//   Pop: when ev_valid & ev_ready, rd_ptr advances at the posedge.
//   Occupancy and pointers:
//   - count ranges 0..DEPTH and needs PTR_W+1 bits.
//   - Pointers wrap modulo DEPTH.
//   - ev_valid = (count != 0).
//   Full (count == DEPTH):
//   - A commit with a same-cycle pop is accepted and count stays DEPTH.
//   - A commit without a pop is dropped, overflow<=1, and FIFO contents are unchanged.
//   Empty plus simultaneous push: the entry is stored, count becomes 1, and ev_valid rises next cycle.
//   Simultaneous push and pop when 0 < count < DEPTH: both pointers advance and count is unchanged.
//   write_count increments on every commit, dropped ones included, and saturates.
//   cycle_count:
//   - Increments every cycle while ~stop.
//   - Holds while stop=1.
//   - Saturates at 16'hFFFF.
//   timeout:
//   - Sets on the cycle after cycle_count==TIMEOUT is first seen.
//   - Stays set until rst.
//   - Does not affect the FIFO.
//   Control: one 2-state FIFO-level FSM, EMPTY and NONEMPTY, derived from count.
//   - EMPTY -> NONEMPTY on push.
//   - NONEMPTY -> EMPTY on pop with count==1 and no push.
//   - The full condition is decoded from count, not kept as a separate state.
//   ev_addr and ev_data drive the head entry combinationally from the registered array.
// TESTING
//   T1 stall-held store:
//   - Stimulus: wen=1 for 4 cycles, stall=1 for the first 3; addr=0, data=65; ev_ready=1.
//   - Required: exactly one event {0,65}, 1 cycle after the commit cycle; write_count=1.
//   T2 back-to-back:
//   - Stimulus: 3 consecutive commits, addr 1,2,3, with ev_ready=0, then ev_ready=1.
//   - Required: events drain in order 1,2,3; ev_valid low after the 3rd pop.
//   T3 full/overflow:
//   - Stimulus: 5 commits with ev_ready=0 at DEPTH=4.
//   - Required: count=4, overflow=1, 5th entry absent, write_count=5.
//   T4 full plus simultaneous pop/push:
//   - Stimulus: FIFO full, one cycle with commit and ev_ready=1.
//   - Required: oldest entry popped, new entry appended, overflow stays 0.
//   T5 counters:
//   - Stimulus: run to TIMEOUT=20 with stop=0, then stop=1 for 10 cycles.
//   - Required: timeout=1 from cycle 21; cycle_count frozen while stop=1.
//   T6 reset mid-run:
//   - Stimulus: assert rst with 2 entries buffered.
//   - Required: next cycle ev_valid=0, all counters=0, flags=0, and old data is never emitted.

Source files
------------

// File: rtl/dmem_write_monitor_if.sv
// rtl/dmem_write_monitor_if.sv - CPU data-memory port and commit-event stream bundle
interface dmem_write_monitor_if;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wen;
    logic        mem_stall;
    logic        ev_valid;
    logic [29:0] ev_addr;
    logic [31:0] ev_data;
    logic        ev_ready;

    modport master (
        output mem_addr, mem_wdata, mem_wen, mem_stall, ev_ready,
        input  ev_valid, ev_addr, ev_data
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_wen, mem_stall, ev_ready,
        output ev_valid, ev_addr, ev_data
    );
endinterface

// File: rtl/dmem_write_monitor.sv
// rtl/dmem_write_monitor.sv - store commit monitor with event FIFO, counters and watchdog
module dmem_write_monitor #(
    parameter int          DEPTH   = 4,
    parameter int          PTR_W   = 2,
    parameter logic [15:0] TIMEOUT = 16'd5000
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_write_monitor_if.slave   bus,
    input  logic                  stop,
    output logic [15:0]           write_count,
    output logic [15:0]           cycle_count,
    output logic                  overflow,
    output logic                  timeout
);

    typedef enum logic {S_EMPTY = 1'b0, S_NONEMPTY = 1'b1} state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_CNT  = (PTR_W + 1)'(1);

    state_t           state;
    state_t           state_nxt;
    logic [29:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             ev_valid_i;
    logic             commit;
    logic             pop;
    logic             full;
    logic             push;

    assign commit = bus.mem_wen & ~bus.mem_stall;
    assign pop    = ev_valid_i & bus.ev_ready;
    assign full   = (count == FULL_CNT);
    // A full FIFO still takes a commit when the head leaves in the same cycle.
    assign push   = commit & (~full | pop);

    always_ff @(posedge clk) begin
        if (rst) state <= S_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY:    if (push) state_nxt = S_NONEMPTY;
            S_NONEMPTY: if (pop && (count == ONE_CNT) && !push) state_nxt = S_EMPTY;
            default:    state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        ev_valid_i  = (state == S_NONEMPTY);
        bus.ev_valid = ev_valid_i;
        bus.ev_addr  = ev_valid_i ? addr_mem[rd_ptr] : 30'd0;
        bus.ev_data  = ev_valid_i ? data_mem[rd_ptr] : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: ev_* are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= bus.mem_addr;
            data_mem[wr_ptr] <= bus.mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_count <= '0;
            cycle_count <= '0;
            overflow    <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            if (commit && (write_count != 16'hFFFF)) write_count <= write_count + 16'd1;
            if (!stop && (cycle_count != 16'hFFFF))  cycle_count <= cycle_count + 16'd1;
            if (commit && full && !pop)              overflow    <= 1'b1;
            if (cycle_count == TIMEOUT)              timeout     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_write_monitor.sv
// tb/tb_dmem_write_monitor.sv - self-checking bench for dmem_write_monitor
module tb_dmem_write_monitor;

    localparam int          DEPTH   = 4;
    localparam logic [15:0] TMO     = 16'd20;

    logic        clk = 1'b0;
    logic        rst;
    logic        stop;
    logic [15:0] write_count;
    logic [15:0] cycle_count;
    logic        overflow;
    logic        timeout;

    dmem_write_monitor_if bus ();

    dmem_write_monitor #(
        .DEPTH   (DEPTH),
        .PTR_W   (2),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .stop        (stop),
        .write_count (write_count),
        .cycle_count (cycle_count),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
    } ev_t;

    typedef struct {
        bit          wen;
        bit          stall;
        bit          rdy;
        logic [29:0] a;
        logic [31:0] d;
        bit          v;
        logic [29:0] ea;
        logic [31:0] ed;
        int          wc;
        bit          ov;
    } vec_t;

    ev_t  q[$];
    vec_t tbl[$];
    int   m_wc, m_cc;
    bit   m_ov, m_to;
    int   nchk = 0;
    int   nerr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an event queue plus plain counters, advanced once per clock edge.
    task automatic model_step(input bit r, input bit wen, input bit stall, input logic [29:0] a,
                              input logic [31:0] d, input bit rdy, input bit stp);
        bit commit, popn, was_full;
        if (r) begin
            q.delete();
            m_wc = 0; m_cc = 0; m_ov = 0; m_to = 0;
            return;
        end
        commit   = wen && !stall;
        popn     = (q.size() != 0) && rdy;
        was_full = (q.size() == DEPTH);
        if (commit && m_wc < 65535) m_wc++;
        if (m_cc == int'(TMO)) m_to = 1;
        if (!stp && m_cc < 65535) m_cc++;
        if (popn) void'(q.pop_front());
        if (commit) begin
            if (!was_full || popn) q.push_back({a, d});
            else                   m_ov = 1;
        end
    endtask

    task automatic drive(input bit r, input bit wen, input bit stall, input logic [29:0] a,
                         input logic [31:0] d, input bit rdy, input bit stp);
        rst           = r;
        bus.mem_wen   = wen;
        bus.mem_stall = stall;
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.ev_ready  = rdy;
        stop          = stp;
        model_step(r, wen, stall, a, d, rdy, stp);
        @(posedge clk);
        #1;
        check("model ev_valid", 64'(bus.ev_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("model ev_addr", 64'(bus.ev_addr), 64'(q[0].a));
            check("model ev_data", 64'(bus.ev_data), 64'(q[0].d));
        end
        check("model write_count", 64'(write_count), 64'(m_wc));
        check("model cycle_count", 64'(cycle_count), 64'(m_cc));
        check("model overflow", 64'(overflow), 64'(m_ov));
        check("model timeout", 64'(timeout), 64'(m_to));
    endtask

    task automatic add(input bit wen, input bit stall, input bit rdy, input int a, input int d,
                       input bit v, input int ea, input int ed, input int wc, input bit ov);
        vec_t t;
        t.wen = wen; t.stall = stall; t.rdy = rdy;
        t.a = 30'(a); t.d = 32'(d);
        t.v = v; t.ea = 30'(ea); t.ed = 32'(ed); t.wc = wc; t.ov = ov;
        tbl.push_back(t);
    endtask

    initial begin
        logic [31:0] ra, rd;
        bit          rr;

        // stall-held store: one event, one cycle after the commit cycle
        for (int i = 0; i < 3; i++) add(1, 1, 1, 0, 65, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 65, 1, 0, 65, 1, 0);
        add(0, 0, 1, 0, 0,  0, 0, 0,  1, 0);
        // back-to-back commits drain in order
        add(1, 0, 0, 1, 11, 1, 1, 11, 2, 0);
        add(1, 0, 0, 2, 12, 1, 1, 11, 3, 0);
        add(1, 0, 0, 3, 13, 1, 1, 11, 4, 0);
        add(0, 0, 1, 0, 0,  1, 2, 12, 4, 0);
        add(0, 0, 1, 0, 0,  1, 3, 13, 4, 0);
        add(0, 0, 1, 0, 0,  0, 0, 0,  4, 0);
        // full plus simultaneous pop and push
        for (int i = 0; i < 4; i++) add(1, 0, 0, 4 + i, 20 + i, 1, 4, 20, 5 + i, 0);
        add(1, 0, 1, 8, 24, 1, 5, 21, 9, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 1, 6 + i, 22 + i, 9, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0, 9, 0);
        // overflow: fifth commit dropped
        for (int i = 0; i < 5; i++) add(1, 0, 0, 9 + i, 25 + i, 1, 9, 25, 10 + i, i == 4);
        for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 1, 10 + i, 26 + i, 14, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 14, 1);

        m_wc = 0; m_cc = 0; m_ov = 0; m_to = 0;
        rst = 1'b1; stop = 1'b0;
        bus.mem_wen = 1'b0; bus.mem_stall = 1'b0; bus.mem_addr = '0;
        bus.mem_wdata = '0; bus.ev_ready = 1'b0;

        drive(1, 0, 0, 0, 0, 0, 0);
        check("reset ev_valid", 64'(bus.ev_valid), 64'd0);
        check("reset ev_addr", 64'(bus.ev_addr), 64'd0);
        check("reset ev_data", 64'(bus.ev_data), 64'd0);
        check("reset write_count", 64'(write_count), 64'd0);
        check("reset cycle_count", 64'(cycle_count), 64'd0);

        foreach (tbl[i]) begin
            drive(0, tbl[i].wen, tbl[i].stall, tbl[i].a, tbl[i].d, tbl[i].rdy, 0);
            check($sformatf("vec%0d ev_valid", i), 64'(bus.ev_valid), 64'(tbl[i].v));
            if (tbl[i].v) begin
                check($sformatf("vec%0d ev_addr", i), 64'(bus.ev_addr), 64'(tbl[i].ea));
                check($sformatf("vec%0d ev_data", i), 64'(bus.ev_data), 64'(tbl[i].ed));
            end
            check($sformatf("vec%0d write_count", i), 64'(write_count), 64'(tbl[i].wc));
            check($sformatf("vec%0d overflow", i), 64'(overflow), 64'(tbl[i].ov));
        end

        // reset with two entries buffered, overflow and timeout both set
        drive(0, 1, 0, 100, 200, 0, 0);
        drive(0, 1, 0, 101, 201, 0, 0);
        check("pre-reset timeout", 64'(timeout), 64'd1);
        drive(1, 1, 0, 102, 202, 1, 0);
        check("midrst ev_valid", 64'(bus.ev_valid), 64'd0);
        check("midrst ev_addr", 64'(bus.ev_addr), 64'd0);
        check("midrst ev_data", 64'(bus.ev_data), 64'd0);
        check("midrst write_count", 64'(write_count), 64'd0);
        check("midrst cycle_count", 64'(cycle_count), 64'd0);
        check("midrst overflow", 64'(overflow), 64'd0);
        check("midrst timeout", 64'(timeout), 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            check("postrst ev_valid", 64'(bus.ev_valid), 64'd0);
        end

        // counters and watchdog from a fresh reset
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 25; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            check("run cycle_count", 64'(cycle_count), 64'(k));
            check("run timeout", 64'(timeout), 64'(k >= 21));
        end
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            check("stop cycle_count", 64'(cycle_count), 64'd25);
            check("stop timeout", 64'(timeout), 64'd1);
        end

        for (int n = 0; n < 2000; n++) begin
            ra = $urandom;
            rd = $urandom;
            rr = ($urandom_range(199) == 0);
            drive(rr, $urandom_range(1) == 1, $urandom_range(9) < 3, ra[29:0], rd,
                  $urandom_range(1) == 1, $urandom_range(9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
